// File: rtl/csr_pkg.sv
// Shared CSR types: per-register access kinds, the response entry and strobe expansion.
// Latency: none (types and a pure function only).
// Backpressure: none.
package csr_pkg;

  // Response entries are sized by this width; csr_bank's CsrDataWidth must match it.
  localparam int unsigned CsrDw    = 32;
  localparam int unsigned CsrStrbW = CsrDw / 8;

  typedef enum logic [1:0] {
    CSR_RW,
    CSR_RO,
    CSR_WP,
    CSR_W1C
  } csr_access_e;

  typedef struct packed {
    logic [CsrDw-1:0] data;
    logic             err;
  } csr_rsp_t;

  // Expand a byte-enable vector into a per-bit write mask.
  function automatic logic [CsrDw-1:0] strb2mask(input logic [CsrStrbW-1:0] strb);
    logic [CsrDw-1:0] m;
    m = '0;
    for (int b = 0; b < CsrStrbW; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_rsp_fifo.sv
// Response FIFO holding csr_rsp_t entries in request order.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full_o blocks pushes unless a pop happens in the same cycle.
module csr_rsp_fifo
  import csr_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  csr_rsp_t push_dat_i,
  input  logic     pop_i,
  output csr_rsp_t head_dat_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  csr_rsp_t        r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  assign full_o     = (r_cnt == CntW'(Depth));
  assign empty_o    = (r_cnt == '0);
  assign w_pop      = pop_i & ~empty_o;
  // A pop frees the slot, so a push alongside it is legal even when full.
  assign w_push     = push_i & (~full_o | w_pop);
  assign head_dat_o = r_mem[r_rptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; reset flushes every queued response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_dat_i;
  end

endmodule

// File: rtl/csr_bank.sv
// CSR register bank with per-register RW/RO/WP/W1C behaviour and one response per request.
// Latency: response at the FIFO head the cycle after accept; register updates visible the cycle after accept.
// Backpressure: csr_req_ready_o drops only when the response FIFO is full (no path from csr_rsp_ready_i).
module csr_bank
  import csr_pkg::*;
#(
  parameter int unsigned NumRegs      = 16,
  parameter int unsigned CsrDataWidth = CsrDw,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned RspFifoDepth = 2,
  parameter csr_access_e AccessMap [NumRegs] = '{default: CSR_RW},
  parameter logic [NumRegs-1:0][CsrDataWidth-1:0] ResetVals = '0,
  localparam int unsigned StrbWidth = CsrDataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [CsrDataWidth-1:0]         csr_req_data_i,
  input  logic [CsrAddrWidth-1:0]         csr_req_addr_i,
  input  logic [StrbWidth-1:0]            csr_req_strb_i,
  input  logic                            csr_req_write_i,
  input  logic                            csr_req_valid_i,
  output logic                            csr_req_ready_o,
  output logic [CsrDataWidth-1:0]         csr_rsp_data_o,
  output logic                            csr_rsp_err_o,
  output logic                            csr_rsp_valid_o,
  input  logic                            csr_rsp_ready_i,
  output logic [NumRegs*CsrDataWidth-1:0] csr_reg_q_o,
  output logic [NumRegs*CsrDataWidth-1:0] csr_pulse_o,
  input  logic [NumRegs*CsrDataWidth-1:0] csr_hw_rd_i,
  input  logic [NumRegs*CsrDataWidth-1:0] csr_hw_set_i
);

  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_accept;
  logic                    w_wr;
  logic                    w_in_range;
  logic [NumRegs-1:0]      w_hit;
  logic [CsrDataWidth-1:0] w_mask;
  logic [CsrDataWidth-1:0] w_wdat;
  logic [CsrDataWidth-1:0] w_rd_dat;
  logic [CsrDataWidth-1:0] w_rd_val [NumRegs];
  csr_rsp_t                w_rsp;
  csr_rsp_t                w_head;
  logic                    w_unused;

  assign csr_req_ready_o = ~w_fifo_full;
  assign w_accept        = csr_req_valid_i & csr_req_ready_o;
  assign w_wr            = w_accept & csr_req_write_i;
  assign w_mask          = strb2mask(csr_req_strb_i);
  assign w_wdat          = csr_req_data_i & w_mask;
  assign w_in_range      = |w_hit;

  // Hardware inputs only matter for RO/W1C slots; fold the rest away.
  assign w_unused = ^{csr_hw_rd_i, csr_hw_set_i};

  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    logic w_wr_sel;
    assign w_hit[i] = (csr_req_addr_i == CsrAddrWidth'(i));
    assign w_wr_sel = w_wr & w_hit[i];

    if (AccessMap[i] == CSR_RW) begin : g_rw
      logic [CsrDataWidth-1:0] r_q;
      // Masked bytes of an accepted write replace the stored value.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_q <= ResetVals[i];
        else if (w_wr_sel) r_q <= (r_q & ~w_mask) | w_wdat;
      end
      assign w_rd_val[i]                              = r_q;
      assign csr_reg_q_o[i*CsrDataWidth +: CsrDataWidth] = r_q;
      assign csr_pulse_o[i*CsrDataWidth +: CsrDataWidth] = '0;

    end else if (AccessMap[i] == CSR_RO) begin : g_ro
      // Reads reflect the live hardware value; writes are acknowledged and dropped.
      assign w_rd_val[i]                              = csr_hw_rd_i[i*CsrDataWidth +: CsrDataWidth];
      assign csr_reg_q_o[i*CsrDataWidth +: CsrDataWidth] = ResetVals[i];
      assign csr_pulse_o[i*CsrDataWidth +: CsrDataWidth] = '0;

    end else if (AccessMap[i] == CSR_WP) begin : g_wp
      logic [CsrDataWidth-1:0] r_pulse;
      // Pulse the masked write data for exactly the cycle after accept.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_pulse <= '0;
        else         r_pulse <= w_wr_sel ? w_wdat : '0;
      end
      assign w_rd_val[i]                              = '0;
      assign csr_reg_q_o[i*CsrDataWidth +: CsrDataWidth] = '0;
      assign csr_pulse_o[i*CsrDataWidth +: CsrDataWidth] = r_pulse;

    end else begin : g_w1c
      logic [CsrDataWidth-1:0] r_q;
      logic [CsrDataWidth-1:0] w_set;
      logic [CsrDataWidth-1:0] w_clr;
      assign w_set = csr_hw_set_i[i*CsrDataWidth +: CsrDataWidth];
      assign w_clr = w_wr_sel ? w_wdat : '0;
      // Sticky hardware set ORed in after the clear, so set wins a collision.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_q <= ResetVals[i];
        else         r_q <= (r_q & ~w_clr) | w_set;
      end
      // A read sees bits being set in the same cycle.
      assign w_rd_val[i]                              = r_q | w_set;
      assign csr_reg_q_o[i*CsrDataWidth +: CsrDataWidth] = r_q;
      assign csr_pulse_o[i*CsrDataWidth +: CsrDataWidth] = '0;
    end
  end

  // Read mux over the register addressed by the request, using pre-update values.
  always_comb begin
    w_rd_dat = '0;
    for (int k = 0; k < NumRegs; k++) begin
      if (w_hit[k]) w_rd_dat = w_rd_val[k];
    end
  end

  assign w_rsp.data = (w_in_range & ~csr_req_write_i) ? w_rd_dat : '0;
  assign w_rsp.err  = ~w_in_range;

  csr_rsp_fifo #(
    .Depth(RspFifoDepth)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (w_accept),
    .push_dat_i(w_rsp),
    .pop_i     (csr_rsp_valid_o & csr_rsp_ready_i),
    .head_dat_o(w_head),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

  assign csr_rsp_valid_o = ~w_fifo_empty;
  assign csr_rsp_data_o  = w_head.data;
  assign csr_rsp_err_o   = w_head.err;

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: directed requests, a per-cycle scoreboard model, and literal response checks.
// Latency: checks outputs on every falling edge; requests are driven just after rising edges.
// Backpressure: exercises a full response FIFO with csr_rsp_ready_i held low.
module tb_csr_bank;
  import csr_pkg::*;

  localparam int N     = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam csr_access_e MAP [N] = '{0: CSR_RW, 1: CSR_RO, 2: CSR_WP, 3: CSR_W1C, default: CSR_RW};
  localparam logic [N-1:0][DW-1:0] RV = {{15{32'h0}}, 32'h000000A5};
  localparam logic [32:0] EXP_LOG [20] = '{
    {1'b0, 32'h000000A5}, {1'b1, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h00340078},
    {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'hDEADBEEF}, {1'b0, 32'h0},
    {1'b0, 32'hDEADBEEF}, {1'b0, 32'h0}, {1'b0, 32'h00000010}, {1'b0, 32'h0},
    {1'b0, 32'h0}, {1'b0, 32'h00000100}, {1'b0, 32'h0}, {1'b0, 32'h00340078},
    {1'b0, 32'h00340078}, {1'b0, 32'hDEADBEEF}, {1'b0, 32'h00000100}, {1'b0, 32'h000000A5}
  };

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [DW-1:0]   csr_req_data_i;
  logic [31:0]     csr_req_addr_i;
  logic [3:0]      csr_req_strb_i;
  logic            csr_req_write_i;
  logic            csr_req_valid_i;
  logic            csr_req_ready_o;
  logic [DW-1:0]   csr_rsp_data_o;
  logic            csr_rsp_err_o;
  logic            csr_rsp_valid_o;
  logic            csr_rsp_ready_i;
  logic [N*DW-1:0] csr_reg_q_o;
  logic [N*DW-1:0] csr_pulse_o;
  logic [N*DW-1:0] csr_hw_rd_i;
  logic [N*DW-1:0] csr_hw_set_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_reg   [N];
  logic [DW-1:0] m_pulse [N];
  logic [32:0]   mq[$];
  logic [32:0]   rsp_log[$];

  always #5 clk_i = ~clk_i;

  csr_bank #(
    .NumRegs     (N),
    .CsrDataWidth(DW),
    .CsrAddrWidth(32),
    .RspFifoDepth(DEPTH),
    .AccessMap   (MAP),
    .ResetVals   (RV)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .csr_req_data_i (csr_req_data_i),
    .csr_req_addr_i (csr_req_addr_i),
    .csr_req_strb_i (csr_req_strb_i),
    .csr_req_write_i(csr_req_write_i),
    .csr_req_valid_i(csr_req_valid_i),
    .csr_req_ready_o(csr_req_ready_o),
    .csr_rsp_data_o (csr_rsp_data_o),
    .csr_rsp_err_o  (csr_rsp_err_o),
    .csr_rsp_valid_o(csr_rsp_valid_o),
    .csr_rsp_ready_i(csr_rsp_ready_i),
    .csr_reg_q_o    (csr_reg_q_o),
    .csr_pulse_o    (csr_pulse_o),
    .csr_hw_rd_i    (csr_hw_rd_i),
    .csr_hw_set_i   (csr_hw_set_i)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] flat(input logic [DW-1:0] a [N]);
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = a[i];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i]   = (MAP[i] == CSR_WP) ? '0 : RV[i];
      m_pulse[i] = '0;
    end
    mq.delete();
  endfunction

  // Scoreboard: compare against the model, then advance it with the inputs the next edge samples.
  initial begin : scoreboard
    logic          pop, acc, in_rng, hit;
    int            idx;
    logic [DW-1:0] mask, wd, rdv, clr, setv;
    logic [DW-1:0] nreg [N];
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        model_reset();
        chk32("rst_rsp_valid", 32'(csr_rsp_valid_o), 32'd0);
        chk32("rst_req_ready", 32'(csr_req_ready_o), 32'd1);
        chkv("rst_reg_q", csr_reg_q_o, flat(m_reg));
        chkv("rst_pulse", csr_pulse_o, flat(m_pulse));
      end else begin
        chk32("req_ready", 32'(csr_req_ready_o), 32'(mq.size() < DEPTH));
        chk32("rsp_valid", 32'(csr_rsp_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk32("rsp_data", csr_rsp_data_o, mq[0][31:0]);
          chk32("rsp_err", 32'(csr_rsp_err_o), 32'(mq[0][32]));
        end
        chkv("reg_q", csr_reg_q_o, flat(m_reg));
        chkv("pulse", csr_pulse_o, flat(m_pulse));

        pop = (mq.size() != 0) && csr_rsp_ready_i;
        if (pop) rsp_log.push_back({csr_rsp_err_o, csr_rsp_data_o});
        acc    = csr_req_valid_i && (mq.size() < DEPTH);
        in_rng = csr_req_addr_i < N;
        idx    = in_rng ? int'(csr_req_addr_i) : 0;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{csr_req_strb_i[b]}};
        wd = csr_req_data_i & mask;

        rdv = '0;
        if (in_rng && !csr_req_write_i) begin
          case (MAP[idx])
            CSR_RW:  rdv = m_reg[idx];
            CSR_RO:  rdv = csr_hw_rd_i[idx*DW +: DW];
            CSR_WP:  rdv = '0;
            default: rdv = m_reg[idx] | csr_hw_set_i[idx*DW +: DW];
          endcase
        end

        for (int i = 0; i < N; i++) begin
          hit        = acc && in_rng && csr_req_write_i && (idx == i);
          nreg[i]    = m_reg[i];
          m_pulse[i] = '0;
          if (MAP[i] == CSR_W1C) begin
            clr     = hit ? wd : '0;
            setv    = csr_hw_set_i[i*DW +: DW];
            nreg[i] = (m_reg[i] & ~clr) | setv;
          end else if (hit && MAP[i] == CSR_RW) begin
            nreg[i] = (m_reg[i] & ~mask) | wd;
          end else if (hit && MAP[i] == CSR_WP) begin
            m_pulse[i] = wd;
          end
        end
        for (int i = 0; i < N; i++) m_reg[i] = nreg[i];
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({~in_rng, rdv});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    csr_req_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  // Present a request and hold it until accepted; valid stays high on return.
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok              = 1'b0;
    csr_req_valid_i = 1'b1;
    csr_req_write_i = wr;
    csr_req_addr_i  = a;
    csr_req_data_i  = d;
    csr_req_strb_i  = s;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk_i);
      ok = csr_req_ready_o;
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout addr=%0d: not accepted in 20 cycles, required accept", a);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_ni          = 1'b0;
    csr_req_valid_i = 1'b0;
    csr_req_write_i = 1'b0;
    csr_req_addr_i  = '0;
    csr_req_data_i  = '0;
    csr_req_strb_i  = '0;
    csr_rsp_ready_i = 1'b1;
    csr_hw_set_i    = '0;
    csr_hw_rd_i     = '0;
    csr_hw_rd_i[1*DW +: DW] = 32'hDEADBEEF;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    chk32("init_ready", 32'(csr_req_ready_o), 32'd1);
    chk32("init_valid", 32'(csr_rsp_valid_o), 32'd0);
    chk32("init_r0", csr_reg_q_o[31:0], 32'h000000A5);
    chkv("init_pulse", csr_pulse_o, '0);

    req(1'b0, 32'd0, 32'h0, 4'h0);
    chk32("rd_r0_valid", 32'(csr_rsp_valid_o), 32'd1);
    chk32("rd_r0_data", csr_rsp_data_o, 32'h000000A5);
    chk32("rd_r0_err", 32'(csr_rsp_err_o), 32'd0);
    req(1'b0, 32'd16, 32'h0, 4'h0);
    chk32("rd_r16_data", csr_rsp_data_o, 32'h0);
    chk32("rd_r16_err", 32'(csr_rsp_err_o), 32'd1);

    chk32("r0_before_wr", csr_reg_q_o[31:0], 32'h000000A5);
    req(1'b1, 32'd0, 32'h12345678, 4'b0101);
    chk32("r0_after_wr", csr_reg_q_o[31:0], 32'h00340078);
    req(1'b0, 32'd0, 32'h0, 4'h0);
    chk32("rd_after_wr", csr_rsp_data_o, 32'h00340078);

    req(1'b1, 32'd2, 32'h9, 4'hF);
    chk32("wp_pulse", csr_pulse_o[95:64], 32'h9);
    chk32("wp_reg_q", csr_reg_q_o[95:64], 32'h0);
    req(1'b0, 32'd2, 32'h0, 4'h0);
    chk32("wp_pulse_gone", csr_pulse_o[95:64], 32'h0);
    chk32("wp_read", csr_rsp_data_o, 32'h0);

    req(1'b0, 32'd1, 32'h0, 4'h0);
    chk32("ro_read", csr_rsp_data_o, 32'hDEADBEEF);
    req(1'b1, 32'd1, 32'hFFFFFFFF, 4'hF);
    chk32("ro_write_err", 32'(csr_rsp_err_o), 32'd0);
    req(1'b0, 32'd1, 32'h0, 4'h0);

    csr_hw_set_i[3*DW + 4] = 1'b1;
    req(1'b1, 32'd3, 32'h10, 4'hF);
    csr_hw_set_i = '0;
    chk32("w1c_set_wins", csr_reg_q_o[127:96], 32'h10);
    req(1'b0, 32'd3, 32'h0, 4'h0);
    req(1'b1, 32'd3, 32'h10, 4'hF);
    chk32("w1c_clear", csr_reg_q_o[127:96], 32'h0);
    req(1'b0, 32'd3, 32'h0, 4'h0);
    csr_hw_set_i[3*DW + 8] = 1'b1;
    req(1'b0, 32'd3, 32'h0, 4'h0);
    csr_hw_set_i = '0;
    chk32("w1c_rd_sees_set", csr_rsp_data_o, 32'h100);

    req(1'b1, 32'd0, 32'hFFFFFFFF, 4'h0);
    chk32("strb0_err", 32'(csr_rsp_err_o), 32'd0);
    chk32("strb0_nochange", csr_reg_q_o[31:0], 32'h00340078);
    req(1'b0, 32'd0, 32'h0, 4'h0);
    idle(1);

    csr_rsp_ready_i = 1'b0;
    req(1'b0, 32'd0, 32'h0, 4'h0);
    req(1'b0, 32'd1, 32'h0, 4'h0);
    csr_req_addr_i = 32'd3;
    @(negedge clk_i);
    chk32("bp_ready_low", 32'(csr_req_ready_o), 32'd0);
    chk32("bp_valid", 32'(csr_rsp_valid_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk32("bp_ready_held", 32'(csr_req_ready_o), 32'd0);
    tick();
    csr_rsp_ready_i = 1'b1;
    req(1'b0, 32'd3, 32'h0, 4'h0);
    idle(4);

    csr_rsp_ready_i = 1'b0;
    req(1'b0, 32'd0, 32'h0, 4'h0);
    req(1'b0, 32'd1, 32'h0, 4'h0);
    csr_req_valid_i = 1'b0;
    chk32("q2_valid", 32'(csr_rsp_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk32("mid_rst_valid", 32'(csr_rsp_valid_o), 32'd0);
    chk32("mid_rst_ready", 32'(csr_req_ready_o), 32'd1);
    chk32("mid_rst_r0", csr_reg_q_o[31:0], 32'h000000A5);
    chk32("mid_rst_r3", csr_reg_q_o[127:96], 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni          = 1'b1;
    csr_rsp_ready_i = 1'b1;
    chk32("post_rst_valid", 32'(csr_rsp_valid_o), 32'd0);
    req(1'b0, 32'd0, 32'h0, 4'h0);
    chk32("post_rst_rd", csr_rsp_data_o, 32'h000000A5);
    idle(3);

    chk32("log_count", 32'(rsp_log.size()), 32'd20);
    for (int i = 0; i < 20 && i < rsp_log.size(); i++) begin
      chk32($sformatf("log%0d_data", i), rsp_log[i][31:0], EXP_LOG[i][31:0]);
      chk32($sformatf("log%0d_err", i), 32'(rsp_log[i][32]), 32'(EXP_LOG[i][32]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
